sensor_monitor: RTL

//  Parametrised successor to the 4-input combinational sensor error decoder.

---
 rtl/sensor_monitor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sensor_monitor.sv
// Debounced N-channel sensor monitor with latched fault, captured source vector and saturating fault counter.
// Optional input synchroniser enabled by defining SENSOR_MON_SYNC_EN.
module sensor_monitor #(
    parameter int NUM_SENSORS     = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   err_clear,
    output logic                   error,
    output logic [NUM_SENSORS-1:0] fault_src,
    output logic [CNT_W-1:0]       fault_count,
    output logic [NUM_SENSORS-1:0] sens_filt
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    logic [NUM_SENSORS-1:0] sens_in_s;
    logic [NUM_SENSORS-1:0] sens_filt_r;
    logic [DB_W-1:0]        db_cnt_r [NUM_SENSORS];
    logic                   cond_s;
    state_t                 state_r;
    logic                   error_r;
    logic [NUM_SENSORS-1:0] fault_src_r;
    logic [CNT_W-1:0]       fault_count_r;

`ifdef SENSOR_MON_SYNC_EN
    logic [NUM_SENSORS-1:0] sync1_r;
    logic [NUM_SENSORS-1:0] sync2_r;

    // Two-flop synchroniser for asynchronous sensor pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= sensors;
            sync2_r <= sync1_r;
        end
    end

    assign sens_in_s = sync2_r;
`else
    assign sens_in_s = sensors;
`endif

    // Per-channel debounce: a new level must persist DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sens_filt_r <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (sens_in_s[i] == sens_filt_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    sens_filt_r[i] <= sens_in_s[i];
                    db_cnt_r[i]    <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Fault rule: channel 0 alone, or channel 1 together with any higher channel
    always_comb begin
        cond_s = sens_filt_r[0] | (sens_filt_r[1] & (|sens_filt_r[NUM_SENSORS-1:2]));
    end

    // Fault latch FSM; clear is honoured only once the fault condition is gone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_OK;
            error_r       <= 1'b0;
            fault_src_r   <= '0;
            fault_count_r <= '0;
        end else begin
            case (state_r)
                ST_OK: begin
                    if (cond_s) begin
                        state_r     <= ST_FAULT;
                        error_r     <= 1'b1;
                        fault_src_r <= sens_filt_r;
                        if (fault_count_r != CNT_MAX) begin
                            fault_count_r <= fault_count_r + CNT_W'(1);
                        end else begin
                            fault_count_r <= fault_count_r;
                        end
                    end else begin
                        state_r <= ST_OK;
                        error_r <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (err_clear && !cond_s) begin
                        state_r <= ST_OK;
                        error_r <= 1'b0;
                    end else begin
                        state_r <= ST_FAULT;
                        error_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_OK;
                    error_r <= 1'b0;
                end
            endcase
        end
    end

    assign error       = error_r;
    assign fault_src   = fault_src_r;
    assign fault_count = fault_count_r;
    assign sens_filt   = sens_filt_r;

endmodule
